// File: rtl/ct_piu_top_stub_responder.sv
// ct_piu_top_stub_responder: drains stray SNB R/B responses with round-robin grant, delayed ack and error logging
module ct_piu_top_stub_responder #(
    parameter int NUM_SNB    = 2,
    parameter int UPKB_WIDTH = 535,
    parameter int B_WIDTH    = 14,
    parameter int ARWIDTH    = 71,
    parameter int AWWIDTH    = 71,
    parameter int WCD_WIDTH  = 535,
    parameter int SID_WIDTH  = 5,
    parameter int R_SID_LSB  = 0,
    parameter int B_SID_LSB  = 0,
    parameter int ACK_DLY    = 1
) (
    input  logic                            forever_cpuclk,
    input  logic                            cpurst,
    input  logic [NUM_SNB-1:0]              snbx_piu_rvalid,
    input  logic [NUM_SNB*UPKB_WIDTH-1:0]   snbx_piux_rbus,
    input  logic [NUM_SNB-1:0]              snbx_piu_bvalid,
    input  logic [NUM_SNB*B_WIDTH-1:0]      snbx_piux_bbus,
    input  logic [NUM_SNB-1:0]              snbx_piu_ar_grant,
    input  logic [NUM_SNB-1:0]              snbx_piu_aw_grant,
    input  logic [NUM_SNB-1:0]              snbx_piu_wcd_grant,
    input  logic                            stub_err_clr,
    output logic [NUM_SNB-1:0]              piu_snbx_ar_req,
    output logic [NUM_SNB-1:0]              piu_snbx_aw_req,
    output logic [NUM_SNB-1:0]              piu_snbx_wcd_req,
    output logic [NUM_SNB*ARWIDTH-1:0]      piu_snbx_ar_bus,
    output logic [AWWIDTH-1:0]              piu_xx_aw_bus,
    output logic [WCD_WIDTH-1:0]            piu_xx_wcd_bus,
    output logic [NUM_SNB-1:0]              piu_snbx_r_grant,
    output logic [NUM_SNB-1:0]              piu_snbx_b_grant,
    output logic [NUM_SNB-1:0]              piu_snbx_rack,
    output logic [SID_WIDTH-1:0]            piu_snbx_rack_sid,
    output logic [NUM_SNB-1:0]              piu_snbx_back,
    output logic [SID_WIDTH-1:0]            piu_snbx_back_sid,
    output logic                            piu_xx_no_op,
    output logic                            stub_err_sticky,
    output logic [7:0]                      stub_err_cnt
);
    localparam int IW = NUM_SNB > 1 ? $clog2(NUM_SNB) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, ACK} state_t;

    logic [NUM_SNB-1:0]   vld [2];
    logic [SID_WIDTH-1:0] bus_sid [2][NUM_SNB];
    logic [NUM_SNB-1:0]   gnt [2];
    logic [NUM_SNB-1:0]   ack [2];
    logic [SID_WIDTH-1:0] ack_sid [2];
    logic [1:0]           acc, viol, idle;
    logic [7:0]           err_base;
    logic [8:0]           err_sum;
    logic                 unused_ok;

    assign vld[0] = snbx_piu_rvalid;
    assign vld[1] = snbx_piu_bvalid;
    for (genvar i = 0; i < NUM_SNB; i++) begin : g_sid
        assign bus_sid[0][i] = snbx_piux_rbus[i*UPKB_WIDTH+R_SID_LSB +: SID_WIDTH];
        assign bus_sid[1][i] = snbx_piux_bbus[i*B_WIDTH+B_SID_LSB +: SID_WIDTH];
    end

    // path 0 drains R responses, path 1 drains B responses
    for (genvar p = 0; p < 2; p++) begin : g_path
        state_t               st, st_n;
        logic [IW-1:0]        sel, ptr, pick, idx;
        logic [SID_WIDTH-1:0] sid;
        logic [3:0]           cnt, cnt_n;
        logic                 found;
        always_comb begin
            found = 1'b0;
            pick  = '0;
            idx   = '0;
            for (int k = 0; k < NUM_SNB; k++) begin
                idx = IW'((int'(ptr) + k) % NUM_SNB);
                if (!found && vld[p][idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
        end
        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            case (st)
                IDLE:  st_n = |vld[p] ? GRANT : IDLE;
                GRANT: begin
                    st_n  = vld[p][sel] ? (ACK_DLY == 1 ? ACK : WAIT) : IDLE;
                    cnt_n = 4'(ACK_DLY - 1);
                end
                WAIT: begin
                    cnt_n = cnt - 4'd1;
                    st_n  = cnt == 4'd1 ? ACK : WAIT;
                end
                default: st_n = IDLE;
            endcase
        end
        always_ff @(posedge forever_cpuclk) begin
            if (cpurst) begin
                st  <= IDLE;
                sel <= '0;
                ptr <= '0;
                sid <= '0;
                cnt <= '0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                if (st == IDLE && found) begin
                    sel <= pick;
                    sid <= bus_sid[p][pick];
                end
                if (st == ACK)
                    ptr <= (int'(sel) == NUM_SNB - 1) ? '0 : sel + 1'b1;
            end
        end
        assign gnt[p]     = (st == GRANT) ? NUM_SNB'(1) << sel : '0;
        assign ack[p]     = (st == ACK) ? NUM_SNB'(1) << sel : '0;
        assign ack_sid[p] = (st == ACK) ? sid : '0;
        assign acc[p]     = (st == GRANT) && vld[p][sel];
        assign viol[p]    = (st == GRANT) && !vld[p][sel];
        assign idle[p]    = st == IDLE;
    end

    // clear applies first so same-cycle accepts still count
    always_comb begin
        err_base = stub_err_clr ? 8'd0 : stub_err_cnt;
        err_sum  = {1'b0, err_base} + {8'd0, acc[0]} + {8'd0, acc[1]};
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            stub_err_cnt    <= '0;
            stub_err_sticky <= 1'b0;
        end else begin
            stub_err_cnt    <= err_sum[8] ? 8'hff : err_sum[7:0];
            stub_err_sticky <= (~stub_err_clr & stub_err_sticky) | (|acc) | (|viol);
        end
    end

    assign piu_snbx_r_grant  = gnt[0];
    assign piu_snbx_b_grant  = gnt[1];
    assign piu_snbx_rack     = ack[0];
    assign piu_snbx_back     = ack[1];
    assign piu_snbx_rack_sid = ack_sid[0];
    assign piu_snbx_back_sid = ack_sid[1];
    assign piu_xx_no_op      = idle[0] & idle[1] & ~|snbx_piu_rvalid & ~|snbx_piu_bvalid;
    assign piu_snbx_ar_req   = '0;
    assign piu_snbx_aw_req   = '0;
    assign piu_snbx_wcd_req  = '0;
    assign piu_snbx_ar_bus   = '0;
    assign piu_xx_aw_bus     = '0;
    assign piu_xx_wcd_bus    = '0;
    assign unused_ok = ^{snbx_piu_ar_grant, snbx_piu_aw_grant, snbx_piu_wcd_grant, snbx_piux_rbus, snbx_piux_bbus};
endmodule
